// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader for the single-cycle RISC-V core.
// Receives a length byte N followed by 4*N program bytes (8N1, LSB first),
// writes each little-endian word to instruction memory at byte address idx<<2,
// then releases the core from reset.
// Optional macro LOADER_CHECKSUM_EN: one trailing byte (XOR of all data bytes)
// must match before the core is released.
//
// Byte receiver: one-cycle pulses byte_valid_q (byte_q holds the data) or
// stop_err_q (bad stop bit, byte dropped). Neither is ever held; the top FSM
// consumes each pulse in the cycle it is high, with no back-pressure.
module imem_uart_loader #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              frame_err
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

    typedef enum logic [2:0] {
        T_WAIT_LEN = 3'd0,
        T_LOAD     = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        T_CHECK    = 3'd2,
`endif
        T_RUN      = 3'd3,
        T_ERROR    = 3'd4
    } top_state_t;

    // Receiver registers
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    byte_state_t      bstate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             byte_valid_q;
    logic             stop_err_q;

    // Loader registers
    top_state_t       tstate_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       bcnt_q;
    logic [31:0]      word_q;
    logic [31:0]      word_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // 8N1 byte receiver: mid-bit sampling, glitch rejection on the start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            bstate_q     <= B_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            case (bstate_q)
                B_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        bstate_q <= B_START;
                        cnt_q    <= '0;
                    end
                end
                B_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        bstate_q <= rx_sync_q ? B_IDLE : B_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt_q == CNT_W'(DIV - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bstate_q <= B_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                B_STOP: begin
                    if (cnt_q == CNT_W'(DIV - 1)) begin
                        cnt_q    <= '0;
                        bstate_q <= B_IDLE;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            stop_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: bstate_q <= B_IDLE;
            endcase
        end
    end

    // Word being assembled with the incoming byte dropped into its lane
    always_comb begin
        word_d = word_q;
        word_d[{bcnt_q, 3'b000} +: 8] = byte_q;
    end

    // Loader FSM: length, word writes, optional checksum, then release the core
    always_ff @(posedge clk) begin
        if (reset) begin
            tstate_q   <= T_WAIT_LEN;
            len_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (tstate_q)
                T_WAIT_LEN: begin
                    if (stop_err_q) begin
                        tstate_q  <= T_ERROR;
                        frame_err <= 1'b1;
                    end else if (byte_valid_q) begin
                        if (byte_q == 8'd0 || byte_q > 8'(DEPTH)) begin
                            tstate_q  <= T_ERROR;
                            frame_err <= 1'b1;
                        end else begin
                            len_q    <= LEN_W'(byte_q);
                            tstate_q <= T_LOAD;
                        end
                    end
                end
                T_LOAD: begin
                    if (stop_err_q) begin
                        tstate_q  <= T_ERROR;
                        frame_err <= 1'b1;
                    end else if (byte_valid_q) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_q;
`endif
                        bcnt_q <= bcnt_q + 1'b1;
                        word_q <= word_d;
                        if (bcnt_q == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_W'({idx_q, 2'b00});
                            imem_wdata <= word_d;
                            idx_q      <= idx_q + 1'b1;
                            if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                                tstate_q <= T_CHECK;
`else
                                tstate_q <= T_RUN;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                T_CHECK: begin
                    if (stop_err_q) begin
                        tstate_q  <= T_ERROR;
                        frame_err <= 1'b1;
                    end else if (byte_valid_q) begin
                        if (byte_q == csum_q) begin
                            tstate_q <= T_RUN;
                        end else begin
                            tstate_q  <= T_ERROR;
                            frame_err <= 1'b1;
                        end
                    end
                end
`endif
                T_RUN: begin
                    // Outputs change one cycle after the last write strobe
                    core_reset <= 1'b0;
                    load_done  <= 1'b1;
                end
                T_ERROR: begin
                    core_reset <= 1'b1;
                    frame_err  <= 1'b1;
                end
                default: tstate_q <= T_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader (DIV = 10). Stimulus tasks push the expected
// imem writes into exp_q; an independent monitor pops and compares on every
// imem_we. Status outputs are checked at fixed points after each scenario.
module tb_imem_uart_loader;

    localparam int DIV    = 10;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              frame_err;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        prog_w[DEPTH];

    imem_uart_loader #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("imem_write", {imem_addr, imem_wdata}, e);
                check("core_reset_during_load", core_reset, 1);
                check("load_done_during_load", load_done, 0);
            end
        end
    end

    // Driver: reset, then verify the reset values of every output
    task automatic apply_reset();
        check("pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        reset   = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_load_done", load_done, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        tick(5);
    endtask

    // Driver: one 8N1 frame followed by one idle bit time
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop_bit;
        tick(DIV);
        uart_rx = 1'b1;
        tick(DIV);
    endtask

    // Driver: length byte, prog_w[0..n-1] little-endian, checksum when enabled.
    // bad_csum corrupts the checksum (or, without the checksum option, appends
    // that byte anyway so the loader must ignore it).
    task automatic send_prog(input int n, input bit bad_csum);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(8'(n), 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({7'(i * 4), prog_w[i]});
            for (int k = 0; k < 4; k++) begin
                send_byte(prog_w[i][k*8 +: 8], 1'b1);
                cs = cs ^ prog_w[i][k*8 +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (cs ^ 8'h07) : cs, 1'b1);
`else
        if (bad_csum) send_byte(cs ^ 8'h07, 1'b1);
`endif
    endtask

    task automatic check_status(input bit exp_done, input bit exp_creset, input bit exp_ferr);
        tick(30);
        check("load_done", load_done, exp_done);
        check("core_reset", core_reset, exp_creset);
        check("frame_err", frame_err, exp_ferr);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bit run_ok;

        apply_reset();

        // Two-word reference program
        prog_w[0] = 32'h0050_0093;
        prog_w[1] = 32'h00A0_0113;
        send_prog(2, 1'b0);
        check_status(1, 0, 0);
        // Bytes after RUN are ignored
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        check_status(1, 0, 0);

        // Bad length values
        apply_reset();
        send_byte(8'h00, 1'b1);
        check_status(0, 1, 1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check_status(0, 1, 1);
        apply_reset();
        send_byte(8'h21, 1'b1);
        check_status(0, 1, 1);

        // Framing error on the first data byte
        apply_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h00, 1'b1);
        check_status(0, 1, 1);

        // Short glitch while idle, then a normal one-word load
        apply_reset();
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(25);
        check_status(0, 1, 0);
        prog_w[0] = 32'hDEAD_BEEF;
        send_prog(1, 1'b0);
        check_status(1, 0, 0);

        // Reset in the middle of a two-word load
        apply_reset();
        prog_w[0] = 32'h1234_5678;
        send_byte(8'h02, 1'b1);
        exp_q.push_back({7'h00, prog_w[0]});
        for (int k = 0; k < 4; k++) send_byte(prog_w[0][k*8 +: 8], 1'b1);
        send_byte(8'hAA, 1'b1);
        tick(10);
        check("midload_core_reset", core_reset, 1);
        apply_reset();
        prog_w[0] = 32'h00C0_0193;
        send_prog(1, 1'b0);
        check_status(1, 0, 0);

        // Checksum byte: 01 93 00 50 00 with trailing C3 (good) / C4 (bad)
        apply_reset();
        prog_w[0] = 32'h0050_0093;
        send_prog(1, 1'b0);
        check_status(1, 0, 0);
        apply_reset();
        send_prog(1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        check_status(0, 1, 1);
`else
        check_status(1, 0, 0);
`endif

        // Randomized programs, plus one full-depth load
        for (int t = 0; t < 7; t++) begin
            apply_reset();
            n = (t == 6) ? DEPTH : $urandom_range(1, 6);
            for (int i = 0; i < n; i++) prog_w[i] = $urandom();
            run_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (t == 3) run_ok = 1'b0;
`endif
            send_prog(n, (t == 3));
            check_status(run_ok, !run_ok, !run_ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
